// File: rtl/vga_pkg.sv
// Shared VGA definitions: active-area size, bus widths, and the direction and
// motion-state encodings used by the sprite motion controller.
package vga_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned RGB_W    = 3;
    localparam int unsigned COORD_W  = 10;
    localparam int unsigned ROM_AW   = 16;

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_t;

    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_MOVE = 1'b1
    } state_t;

endpackage

// File: rtl/sprite_axis_step.sv
// One axis of sprite motion: position and direction registers. On each step
// the position advances by STEP and bounces off 0 and LIMIT-SIZE.
module sprite_axis_step
    import vga_pkg::*;
#(
    parameter int unsigned LIMIT = 640,
    parameter int unsigned SIZE  = 128,
    parameter int unsigned STEP  = 2,
    parameter int unsigned INIT  = 0
) (
    input  logic               clock_25MHz,
    input  logic               reset_n,
    input  logic               step_en,
    output logic [COORD_W-1:0] pos,
    output dir_t               dir
);

    localparam int unsigned         SUM_W  = COORD_W + 1;
    localparam logic [SUM_W-1:0]    FAR    = SUM_W'(SIZE + STEP);
    localparam logic [SUM_W-1:0]    LIM    = SUM_W'(LIMIT);
    localparam logic [COORD_W-1:0]  MAXP   = COORD_W'(LIMIT - SIZE);
    localparam logic [COORD_W-1:0]  STEP_C = COORD_W'(STEP);
    localparam logic [COORD_W-1:0]  INIT_C = COORD_W'(INIT);

    // Far edge after the next step, kept at 11 bits so it cannot wrap.
    logic [SUM_W-1:0] far_edge;
    assign far_edge = {1'b0, pos} + FAR;

    // Position/direction update with bounce at both screen edges.
    always_ff @(posedge clock_25MHz) begin
        if (!reset_n) begin
            pos <= INIT_C;
            dir <= DIR_POS;
        end else if (step_en) begin
            if (dir == DIR_POS) begin
                if (far_edge > LIM) begin
                    pos <= MAXP;
                    dir <= DIR_NEG;
                end else begin
                    pos <= pos + STEP_C;
                end
            end else begin
                if (pos < STEP_C) begin
                    pos <= '0;
                    dir <= DIR_POS;
                end else begin
                    pos <= pos - STEP_C;
                end
            end
        end
    end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Sprite motion controller: maps the VGA scan position into a bouncing sprite
// window, addresses the sprite ROM and produces 1-bit R/G/B, 3 clocks after
// pixel_row/pixel_col. Optional macro SPRITE_TRANSPARENT_EN makes ROM colour
// 3'b000 inside the window show the background instead of black.
module sprite_motion_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned     SPR_W_LOG2 = 7,
    parameter int unsigned     SPR_H      = 128,
    parameter int unsigned     STEP       = 2,
    parameter int unsigned     X0         = 0,
    parameter int unsigned     Y0         = 0,
    parameter logic [RGB_W-1:0] BG_RGB    = 3'b001
) (
    input  logic               clock_25MHz,
    input  logic               reset_n,
    input  logic [COORD_W-1:0] pixel_row,
    input  logic [COORD_W-1:0] pixel_col,
    input  logic               vsync,
    input  logic               run,
    output logic [ROM_AW-1:0]  rom_addr,
    input  logic [RGB_W-1:0]   rom_dout,
    output logic               red,
    output logic               green,
    output logic               blue,
    output logic [COORD_W-1:0] x_pos,
    output logic [COORD_W-1:0] y_pos
);

    localparam int unsigned SPR_W = 2 ** SPR_W_LOG2;
    localparam int unsigned SUM_W = COORD_W + 1;
    localparam int unsigned ROW_W = $clog2(SPR_H);

    logic   vs_d1, vs_d2;
    logic   tick;
    state_t state;
    logic   step_en;
    dir_t   dir_x, dir_y;

    // Registered vsync history; cleared so a low vsync at reset cannot tick.
    always_ff @(posedge clock_25MHz) begin
        if (!reset_n) begin
            vs_d1 <= 1'b0;
            vs_d2 <= 1'b0;
        end else begin
            vs_d1 <= vsync;
            vs_d2 <= vs_d1;
        end
    end

    assign tick = vs_d2 & ~vs_d1;

    // HOLD/MOVE selection, re-evaluated only at frame ticks.
    always_ff @(posedge clock_25MHz) begin
        if (!reset_n) begin
            state <= ST_HOLD;
        end else if (tick) begin
            case (state)
                ST_HOLD: state <= run ? ST_MOVE : ST_HOLD;
                ST_MOVE: state <= run ? ST_MOVE : ST_HOLD;
                default: state <= ST_HOLD;
            endcase
        end
    end

    assign step_en = tick && (state == ST_MOVE);

    sprite_axis_step #(
        .LIMIT (H_ACTIVE),
        .SIZE  (SPR_W),
        .STEP  (STEP),
        .INIT  (X0)
    ) u_axis_x (
        .clock_25MHz (clock_25MHz),
        .reset_n     (reset_n),
        .step_en     (step_en),
        .pos         (x_pos),
        .dir         (dir_x)
    );

    sprite_axis_step #(
        .LIMIT (V_ACTIVE),
        .SIZE  (SPR_H),
        .STEP  (STEP),
        .INIT  (Y0)
    ) u_axis_y (
        .clock_25MHz (clock_25MHz),
        .reset_n     (reset_n),
        .step_en     (step_en),
        .pos         (y_pos),
        .dir         (dir_y)
    );

    logic [SUM_W-1:0]      x_end, y_end;
    logic                  in_box_c, active_c;
    logic [SPR_W_LOG2-1:0] col_off;
    logic [ROW_W-1:0]      row_off;

    assign x_end = {1'b0, x_pos} + SUM_W'(SPR_W);
    assign y_end = {1'b0, y_pos} + SUM_W'(SPR_H);

    assign in_box_c = (pixel_col >= x_pos) && ({1'b0, pixel_col} < x_end) &&
                      (pixel_row >= y_pos) && ({1'b0, pixel_row} < y_end);
    assign active_c = (pixel_col < COORD_W'(H_ACTIVE)) &&
                      (pixel_row < COORD_W'(V_ACTIVE));

    // Offsets are only used inside the window, where they fit in the low
    // bits, so subtracting just the low bits gives the same result.
    assign col_off = pixel_col[SPR_W_LOG2-1:0] - x_pos[SPR_W_LOG2-1:0];
    assign row_off = pixel_row[ROW_W-1:0] - y_pos[ROW_W-1:0];

    logic s1_in_box, s1_active;
    logic s2_in_box, s2_active;

    // S1: window hit test, active-area test and ROM address.
    always_ff @(posedge clock_25MHz) begin
        if (!reset_n) begin
            rom_addr  <= '0;
            s1_in_box <= 1'b0;
            s1_active <= 1'b0;
        end else begin
            rom_addr  <= in_box_c ? ROM_AW'({row_off, col_off}) : '0;
            s1_in_box <= in_box_c;
            s1_active <= active_c;
        end
    end

    // S2: carry the flags alongside the ROM read.
    always_ff @(posedge clock_25MHz) begin
        if (!reset_n) begin
            s2_in_box <= 1'b0;
            s2_active <= 1'b0;
        end else begin
            s2_in_box <= s1_in_box;
            s2_active <= s1_active;
        end
    end

    logic [RGB_W-1:0] pix_c;

    // Colour select: black off-screen, sprite inside the window, else background.
    always_comb begin
        pix_c = '0;
        if (!s2_active) begin
            pix_c = '0;
        end else if (s2_in_box) begin
`ifdef SPRITE_TRANSPARENT_EN
            pix_c = (rom_dout == '0) ? BG_RGB : rom_dout;
`else
            pix_c = rom_dout;
`endif
        end else begin
            pix_c = BG_RGB;
        end
    end

    // S3: registered colour outputs.
    always_ff @(posedge clock_25MHz) begin
        if (!reset_n) begin
            {red, green, blue} <= '0;
        end else begin
            {red, green, blue} <= pix_c;
        end
    end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Bench for sprite_motion_ctrl: directed stimulus, a behavioural position and
// pixel model, and literal pins for the key values.
module tb_sprite_motion_ctrl;

    logic       clock_25MHz = 1'b0;
    logic       reset_n;
    logic [9:0] pixel_row, pixel_col;
    logic       vsync, run;
    logic [15:0] rom_addr;
    logic [2:0] rom_dout;
    logic       red, green, blue;
    logic [9:0] x_pos, y_pos;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #20 clock_25MHz = ~clock_25MHz;

    sprite_motion_ctrl dut (
        .clock_25MHz (clock_25MHz),
        .reset_n     (reset_n),
        .pixel_row   (pixel_row),
        .pixel_col   (pixel_col),
        .vsync       (vsync),
        .run         (run),
        .rom_addr    (rom_addr),
        .rom_dout    (rom_dout),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .x_pos       (x_pos),
        .y_pos       (y_pos)
    );

    // ROM contents: xor-fold of the address; address 649 holds 3'b101, address 6 holds 3'b000.
    function automatic logic [2:0] rom_fn(input logic [15:0] a);
        return a[2:0] ^ a[5:3] ^ a[8:6] ^ a[11:9] ^ a[14:12] ^ {2'b00, a[15]} ^ 3'b110;
    endfunction

    always @(posedge clock_25MHz) rom_dout <= rom_fn(rom_addr);

    // Behavioural model state
    int m_x, m_y, m_dx, m_dy;
    bit m_move;
    bit tick_pending;

    logic [2:0]  cur_rgb;
    logic [15:0] cur_addr;
    bit          cur_v;
    logic [2:0]  e_rgb[3];
    logic [15:0] e_addr[3];
    bit          e_v[3];

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic axis(inout int p, inout int d, input int lim, input int size);
        if (d > 0) begin
            if (p + size + 2 > lim) begin p = lim - size; d = -1; end
            else p = p + 2;
        end else begin
            if (p < 2) begin p = 0; d = 1; end
            else p = p - 2;
        end
    endtask

    function automatic bit in_win(input int row, input int col);
        return col >= m_x && col < m_x + 128 && row >= m_y && row < m_y + 128;
    endfunction

    function automatic logic [15:0] exp_addr(input int row, input int col);
        if (!in_win(row, col)) return 16'd0;
        return 16'((row - m_y) * 128 + (col - m_x));
    endfunction

    function automatic logic [2:0] exp_pix(input int row, input int col);
        logic [2:0] d;
        if (col >= 640 || row >= 480) return 3'b000;
        if (!in_win(row, col)) return 3'b001;
        d = rom_fn(exp_addr(row, col));
`ifdef SPRITE_TRANSPARENT_EN
        if (d == 3'b000) return 3'b001;
`endif
        return d;
    endfunction

    task automatic drive_pix(input int row, input int col, input bit v);
        pixel_row = 10'(row);
        pixel_col = 10'(col);
        cur_rgb   = exp_pix(row, col);
        cur_addr  = exp_addr(row, col);
        cur_v     = v;
    endtask

    // One clock: advance the model at the edge, then compare on the falling edge.
    task automatic cyc();
        @(posedge clock_25MHz);
        if (!reset_n) begin
            m_x = 0; m_y = 0; m_dx = 1; m_dy = 1; m_move = 0;
            for (int i = 0; i < 3; i++) e_v[i] = 0;
        end else begin
            e_rgb[2] = e_rgb[1]; e_addr[2] = e_addr[1]; e_v[2] = e_v[1];
            e_rgb[1] = e_rgb[0]; e_addr[1] = e_addr[0]; e_v[1] = e_v[0];
            e_rgb[0] = cur_rgb;  e_addr[0] = cur_addr;  e_v[0] = cur_v;
            if (tick_pending) begin
                if (m_move) begin
                    axis(m_x, m_dx, 640, 128);
                    axis(m_y, m_dy, 480, 128);
                end
                m_move = run;
            end
        end
        tick_pending = 0;
        @(negedge clock_25MHz);
        chk("x_pos", x_pos, m_x);
        chk("y_pos", y_pos, m_y);
        if (e_v[0]) chk("rom_addr", rom_addr, e_addr[0]);
        if (e_v[2]) chk("rgb", {red, green, blue}, e_rgb[2]);
    endtask

    // One vsync pulse; the position/state update lands on the second edge after the fall.
    task automatic frame();
        cur_v = 0;
        vsync = 1'b1; cyc(); cyc();
        vsync = 1'b0; cyc();
        tick_pending = 1; cyc();
        cyc();
    endtask

    task automatic pix_lit(input int row, input int col, input int unsigned a_lit,
                           input int unsigned rgb_lit, input string name);
        drive_pix(row, col, 1);
        cyc();
        chk({name, "_addr"}, rom_addr, a_lit);
        cyc(); cyc();
        chk({name, "_rgb"}, {red, green, blue}, rgb_lit);
        cur_v = 0;
    endtask

    task automatic pix_stream(input int base_r, input int base_c);
        int rows[6] = '{-1, 0, 5, 127, 128, 200};
        int cols[6] = '{-1, 0, 9, 127, 128, 700};
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                if (base_r + rows[r] >= 0 && base_c + cols[c] >= 0) begin
                    drive_pix(base_r + rows[r], base_c + cols[c], 1);
                    cyc();
                end
        drive_pix(479, 639, 1); cyc();
        drive_pix(480, 10, 1);  cyc();
        cur_v = 0;
        cyc(); cyc(); cyc();
    endtask

    initial begin
        int  pdx, pdy;
        bit  x_after, found;
        m_x = 0; m_y = 0; m_dx = 1; m_dy = 1; m_move = 0; tick_pending = 0;
        cur_v = 0; cur_rgb = '0; cur_addr = '0;
        for (int i = 0; i < 3; i++) begin e_v[i] = 0; e_rgb[i] = '0; e_addr[i] = '0; end
        reset_n = 1'b0; vsync = 1'b0; run = 1'b1;
        pixel_row = '0; pixel_col = '0;

        // Reset held 3 clocks with vsync low
        cyc(); cyc(); cyc();
        chk("reset_rgb", {red, green, blue}, 0);
        chk("reset_addr", rom_addr, 0);
        chk("reset_x", x_pos, 0);
        chk("reset_y", y_pos, 0);

        // Release with vsync low: no tick, so a run=0 frame must leave position alone
        reset_n = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        run = 1'b0;
        frame();
        chk("no_tick_after_reset_x", x_pos, 0);

        // Address map and colour at the origin
        pix_lit(5, 9, 649, 3'b101, "p_5_9");
        pix_lit(5, 128, 0, 3'b001, "p_5_128");
        pix_lit(5, 700, 0, 3'b000, "p_5_700");
`ifdef SPRITE_TRANSPARENT_EN
        pix_lit(0, 6, 6, 3'b001, "p_transp");
`else
        pix_lit(0, 6, 6, 3'b000, "p_transp");
`endif
        pix_stream(0, 0);

        // Motion: 10 ticks with run=1, then stop
        run = 1'b1;
        for (int i = 0; i < 10; i++) frame();
        chk("move10_x", x_pos, 18);
        chk("move10_y", y_pos, 18);
        run = 1'b0;
        frame();
        chk("stop_tick_x", x_pos, 20);
        frame();
        chk("frozen_x", x_pos, 20);
        chk("frozen_y", y_pos, 20);

        pix_stream(20, 20);

        // Long run through bounces until x returns to 300 moving left
        run = 1'b1;
        frame();
        x_after = 0;
        found = 0;
        for (int i = 0; i < 600 && !found; i++) begin
            pdx = m_dx; pdy = m_dy;
            frame();
            if (x_after) begin
                chk("x_after_bounce", x_pos, 510);
                x_after = 0;
            end
            if (pdx > 0 && m_dx < 0) begin
                chk("x_right_bounce", x_pos, 512);
                x_after = 1;
            end
            if (pdy > 0 && m_dy < 0) chk("y_bottom_bounce", y_pos, 352);
            if (pdy < 0 && m_dy > 0) chk("y_top_bounce", y_pos, 0);
            if (m_x == 300 && m_dx < 0) found = 1;
        end
        chk("reach_x300", x_pos, 300);

        // Mid-frame reset while moving
        drive_pix(m_y + 3, m_x + 4, 1);
        cyc(); cyc(); cyc();
        reset_n = 1'b0;
        cyc();
        chk("midreset_x", x_pos, 0);
        chk("midreset_y", y_pos, 0);
        chk("midreset_rgb", {red, green, blue}, 0);
        reset_n = 1'b1;
        cur_v = 0;
        cyc();
        frame();
        chk("midreset_hold_x", x_pos, 0);
        frame();
        chk("midreset_move_x", x_pos, 2);
        chk("midreset_move_y", y_pos, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
